cluster_round_ctrl: RTL and testbench

Per-node round sequencer for the EER-RL clustered WSN node. Each round it pulses en_MNI so the node-info block re-evaluates role and low_E. It then drives the cluster-head advertisement or join handshake toward the radio TX path and runs the TDMA frame schedule. It sits between the round timer/radio interface and myNodeInfo, and owns all round-phase timing.

---
 rtl/node_pkg.sv | 21 ++
 rtl/tdma_slot_timer.sv | 48 ++++
 rtl/cluster_round_ctrl.sv | 131 +++++++++++++
 tb/tb_cluster_round_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/node_pkg.sv
// Definitions shared by the node's round sequencer and myNodeInfo: round phase
// codes, radio tx message codes and the node word width.
package node_pkg;

   localparam int NODE_W = 16;
   typedef logic [NODE_W-1:0] node_word_t;

   localparam logic [2:0] PH_IDLE     = 3'd0;
   localparam logic [2:0] PH_UPDATE   = 3'd1;
   localparam logic [2:0] PH_SETTLE   = 3'd2;
   localparam logic [2:0] PH_ANNOUNCE = 3'd3;
   localparam logic [2:0] PH_JOIN     = 3'd4;
   localparam logic [2:0] PH_TDMA     = 3'd5;

   typedef enum logic [1:0] {
      TX_NONE     = 2'b00,
      TX_CH_ADV   = 2'b01,
      TX_JOIN_REQ = 2'b10
   } tx_type_t;

endpackage

// File: rtl/tdma_slot_timer.sv
// TDMA frame timing: cycles within a slot, slot index within a frame, frames per round.
// Held cleared whenever the round is not in its TDMA phase.
module tdma_slot_timer #(
   parameter int SLOT_LEN    = 8,
   parameter int MAX_MEMBERS = 7,
   parameter int FRAMES      = 4
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       run,
   output logic [7:0] timeslot,
   output logic       frame_wrap,
   output logic       last_frame
);

   localparam int CW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
   localparam int FW = $clog2(FRAMES + 1);
   localparam logic [CW-1:0] CYC_LAST   = CW'(SLOT_LEN - 1);
   localparam logic [7:0]    SLOT_LAST  = 8'(MAX_MEMBERS);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);

   logic [CW-1:0] cyc;
   logic [FW-1:0] frame_cnt;
   logic          slot_end;

   assign slot_end   = cyc == CYC_LAST;
   assign frame_wrap = run && slot_end && (timeslot == SLOT_LAST);
   assign last_frame = frame_cnt == FRAME_LAST;

   always_ff @(posedge clk) begin
      if (!nrst || !run) begin
         cyc       <= '0;
         timeslot  <= '0;
         frame_cnt <= '0;
      end else if (slot_end) begin
         cyc <= '0;
         if (timeslot == SLOT_LAST) begin
            timeslot  <= '0;
            frame_cnt <= frame_cnt + 1'b1;
         end else begin
            timeslot <= timeslot + 8'd1;
         end
      end else begin
         cyc <= cyc + 1'b1;
      end
   end

endmodule

// File: rtl/cluster_round_ctrl.sv
// Per-round sequencer for a clustered WSN node: node-info refresh, CH advertisement
// or join handshake, then the TDMA frame schedule until the round ends.
module cluster_round_ctrl
   import node_pkg::*;
#(
   parameter int JOIN_WIN    = 16,
   parameter int SLOT_LEN    = 8,
   parameter int MAX_MEMBERS = 7,
   parameter int FRAMES      = 4
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       start_round,
   input  logic       role,
   input  logic       low_E,
   input  logic       tx_ack,
   input  logic       join_rx,
   input  logic       slot_rx,
   input  logic [7:0] slot_idx_in,
   output logic       en_MNI,
   output logic       tx_req,
   output logic [1:0] tx_type,
   output logic [7:0] timeslot,
   output logic       my_slot,
   output logic [7:0] member_count,
   output logic [2:0] phase,
   output logic       round_done
);

   localparam int WW = $clog2(JOIN_WIN);
   localparam logic [WW-1:0] WIN_LAST = WW'(JOIN_WIN - 1);
   localparam logic [7:0]    MAXM     = 8'(MAX_MEMBERS);

   logic [2:0]    state;
   logic [2:0]    state_nx;
   logic          is_ch;
   logic          join_acked;
   logic          low_e_seen;
   logic          slot_valid;
   logic [7:0]    slot_reg;
   logic [WW-1:0] win_cnt;
   logic          in_join;
   logic          in_tdma;
   logic          join_pending;
   logic          slot_accept;
   logic          frame_wrap;
   logic          last_frame;
   logic          round_end;

   assign in_join      = state == PH_JOIN;
   assign in_tdma      = state == PH_TDMA;
   assign join_pending = in_join && !is_ch && !join_acked;
   assign slot_accept  = in_join && !is_ch && slot_rx &&
                         (slot_idx_in != 8'd0) && (slot_idx_in <= MAXM);
   // low_E on the wrap cycle itself also ends the round at this frame boundary
   assign round_end    = in_tdma && frame_wrap && (last_frame || low_e_seen || low_E);

   tdma_slot_timer #(
      .SLOT_LEN   (SLOT_LEN),
      .MAX_MEMBERS(MAX_MEMBERS),
      .FRAMES     (FRAMES)
   ) u_timer (
      .clk       (clk),
      .nrst      (nrst),
      .run       (in_tdma),
      .timeslot  (timeslot),
      .frame_wrap(frame_wrap),
      .last_frame(last_frame)
   );

   always_comb begin
      state_nx = state;
      case (state)
         PH_IDLE:     if (start_round) state_nx = PH_UPDATE;
         PH_UPDATE:   state_nx = PH_SETTLE;
         PH_SETTLE:   state_nx = role ? PH_ANNOUNCE : PH_JOIN;
         PH_ANNOUNCE: if (tx_ack) state_nx = PH_JOIN;
         PH_JOIN:     if (win_cnt == WIN_LAST) state_nx = PH_TDMA;
         PH_TDMA:     if (round_end) state_nx = PH_IDLE;
         default:     state_nx = PH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state        <= PH_IDLE;
         is_ch        <= 1'b0;
         join_acked   <= 1'b0;
         low_e_seen   <= 1'b0;
         slot_valid   <= 1'b0;
         win_cnt      <= '0;
         member_count <= '0;
         round_done   <= 1'b0;
      end else begin
         state      <= state_nx;
         round_done <= round_end;
         low_e_seen <= in_tdma && (low_e_seen || low_E);
         win_cnt    <= (in_join && (win_cnt != WIN_LAST)) ? win_cnt + 1'b1 : '0;
         if (state == PH_UPDATE) begin
            member_count <= '0;
            slot_valid   <= 1'b0;
         end
         if (state == PH_SETTLE) begin
            is_ch      <= role;
            join_acked <= 1'b0;
         end
         if (in_join && !is_ch && tx_ack) join_acked <= 1'b1;
         if (in_join && is_ch && join_rx && (member_count < MAXM))
            member_count <= member_count + 8'd1;
         if (slot_accept) slot_valid <= 1'b1;
      end
   end

   // Slot value is only meaningful while slot_valid is set, so it carries no reset.
   always_ff @(posedge clk) begin
      if (slot_accept) slot_reg <= slot_idx_in;
   end

   assign phase   = state;
   assign en_MNI  = state == PH_UPDATE;
   assign tx_req  = (state == PH_ANNOUNCE) || join_pending;
   assign my_slot = in_tdma && (is_ch ? (timeslot == 8'd0)
                                      : (slot_valid && (timeslot == slot_reg)));

   always_comb begin
      tx_type = TX_NONE;
      if (state == PH_ANNOUNCE) tx_type = TX_CH_ADV;
      else if (join_pending)    tx_type = TX_JOIN_REQ;
   end

endmodule

// File: tb/tb_cluster_round_ctrl.sv
// Randomized round-level bench for cluster_round_ctrl; expected outputs come from
// round timing arithmetic (window lengths, slot/frame positions) kept in the bench.
module tb_cluster_round_ctrl;

   localparam int JOIN_WIN    = 8;
   localparam int SLOT_LEN    = 4;
   localparam int MAX_MEMBERS = 3;
   localparam int FRAMES      = 2;
   localparam int FLEN        = SLOT_LEN * (MAX_MEMBERS + 1);

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       start_round = 1'b0;
   logic       role = 1'b0;
   logic       low_E = 1'b0;
   logic       tx_ack = 1'b0;
   logic       join_rx = 1'b0;
   logic       slot_rx = 1'b0;
   logic [7:0] slot_idx_in = 8'd0;
   logic       en_MNI;
   logic       tx_req;
   logic [1:0] tx_type;
   logic [7:0] timeslot;
   logic       my_slot;
   logic [7:0] member_count;
   logic [2:0] phase;
   logic       round_done;

   int vectors = 0;
   int miscompares = 0;

   // per-round stimulus plan
   int ann_ack;
   bit join_pat [JOIN_WIN];
   int slot_pat [JOIN_WIN];
   int ack_j;
   int low_t;
   int start_t;
   int abort_j;

   cluster_round_ctrl #(
      .JOIN_WIN   (JOIN_WIN),
      .SLOT_LEN   (SLOT_LEN),
      .MAX_MEMBERS(MAX_MEMBERS),
      .FRAMES     (FRAMES)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .start_round (start_round),
      .role        (role),
      .low_E       (low_E),
      .tx_ack      (tx_ack),
      .join_rx     (join_rx),
      .slot_rx     (slot_rx),
      .slot_idx_in (slot_idx_in),
      .en_MNI      (en_MNI),
      .tx_req      (tx_req),
      .tx_type     (tx_type),
      .timeslot    (timeslot),
      .my_slot     (my_slot),
      .member_count(member_count),
      .phase       (phase),
      .round_done  (round_done)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input int obs, input int exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_inputs();
      start_round = 1'b0;
      low_E       = 1'b0;
      tx_ack      = 1'b0;
      join_rx     = 1'b0;
      slot_rx     = 1'b0;
      slot_idx_in = 8'd0;
   endtask

   task automatic clear_plan();
      ann_ack = 0;
      ack_j   = 99;
      low_t   = -1;
      start_t = -1;
      abort_j = -1;
      for (int j = 0; j < JOIN_WIN; j++) begin
         join_pat[j] = 1'b0;
         slot_pat[j] = -1;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk_eq({tag, "_en"},    32'(en_MNI), 0);
      chk_eq({tag, "_req"},   32'(tx_req), 0);
      chk_eq({tag, "_type"},  32'(tx_type), 0);
      chk_eq({tag, "_ts"},    32'(timeslot), 0);
      chk_eq({tag, "_my"},    32'(my_slot), 0);
      chk_eq({tag, "_cnt"},   32'(member_count), 0);
      chk_eq({tag, "_phase"}, 32'(phase), 0);
      chk_eq({tag, "_done"},  32'(round_done), 0);
   endtask

   task automatic run_round(input bit ch);
      int  acnt;
      bit  acked;
      bit  sv;
      int  sidx;
      int  own;
      int  nframes;
      int  end_len;
      int  ts;
      zero_inputs();
      role = ch;
      start_round = 1'b1;
      step();
      start_round = 1'b0;
      chk_eq("update_en", 32'(en_MNI), 1);
      chk_eq("update_phase", 32'(phase), 1);
      chk_eq("update_req", 32'(tx_req), 0);
      step();
      chk_eq("settle_en", 32'(en_MNI), 0);
      chk_eq("settle_phase", 32'(phase), 2);
      chk_eq("settle_cnt", 32'(member_count), 0);
      step();
      if (ch) begin
         for (int c = 0; c <= ann_ack; c++) begin
            chk_eq("ann_phase", 32'(phase), 3);
            chk_eq("ann_req", 32'(tx_req), 1);
            chk_eq("ann_type", 32'(tx_type), 1);
            chk_eq("ann_en", 32'(en_MNI), 0);
            tx_ack = (c == ann_ack);
            step();
         end
         tx_ack = 1'b0;
      end
      acnt = 0; acked = 1'b0; sv = 1'b0; sidx = 0;
      for (int j = 0; j < JOIN_WIN; j++) begin
         chk_eq("join_phase", 32'(phase), 4);
         chk_eq("join_req", 32'(tx_req), (!ch && !acked) ? 1 : 0);
         chk_eq("join_type", 32'(tx_type), (!ch && !acked) ? 2 : 0);
         chk_eq("join_cnt", 32'(member_count), acnt);
         if (abort_j == j) begin
            zero_inputs();
            nrst = 1'b0;
            step();
            chk_all_zero("abort");
            nrst = 1'b1;
            step();
            chk_eq("abort_idle_phase", 32'(phase), 0);
            chk_eq("abort_idle_req", 32'(tx_req), 0);
            return;
         end
         join_rx     = ch && join_pat[j];
         slot_rx     = !ch && (slot_pat[j] >= 0);
         slot_idx_in = (slot_pat[j] >= 0) ? 8'(slot_pat[j]) : 8'($urandom_range(0, 255));
         tx_ack      = !ch && (j == ack_j);
         step();
         if (join_rx && acnt < MAX_MEMBERS) acnt++;
         if (tx_ack) acked = 1'b1;
         if (slot_rx && slot_pat[j] >= 1 && slot_pat[j] <= MAX_MEMBERS) begin
            sv = 1'b1;
            sidx = slot_pat[j];
         end
      end
      zero_inputs();
      own     = ch ? 0 : (sv ? sidx : -1);
      nframes = (low_t >= 0 && low_t < FRAMES * FLEN) ? (low_t / FLEN + 1) : FRAMES;
      end_len = nframes * FLEN;
      for (int t = 0; t < end_len; t++) begin
         ts = (t / SLOT_LEN) % (MAX_MEMBERS + 1);
         chk_eq("tdma_phase", 32'(phase), 5);
         chk_eq("tdma_ts", 32'(timeslot), ts);
         chk_eq("tdma_my", 32'(my_slot), (ts == own) ? 1 : 0);
         chk_eq("tdma_done", 32'(round_done), 0);
         chk_eq("tdma_req", 32'(tx_req), 0);
         chk_eq("tdma_cnt", 32'(member_count), acnt);
         low_E       = (t == low_t);
         start_round = (t == start_t);
         step();
      end
      zero_inputs();
      chk_eq("end_done", 32'(round_done), 1);
      chk_eq("end_phase", 32'(phase), 0);
      chk_eq("end_ts", 32'(timeslot), 0);
      chk_eq("end_my", 32'(my_slot), 0);
      chk_eq("end_cnt", 32'(member_count), acnt);
      step();
      chk_eq("post_done", 32'(round_done), 0);
      chk_eq("post_phase", 32'(phase), 0);
      chk_eq("post_en", 32'(en_MNI), 0);
   endtask

   initial begin
      zero_inputs();
      nrst = 1'b0;
      step();
      step();
      chk_all_zero("reset");
      nrst = 1'b1;
      step();
      chk_eq("idle_phase", 32'(phase), 0);
      chk_eq("idle_en", 32'(en_MNI), 0);

      // CH round: ack 3 cycles into ANNOUNCE, two joins
      clear_plan();
      ann_ack = 3;
      join_pat[1] = 1'b1;
      join_pat[4] = 1'b1;
      run_round(1'b1);

      // member round: ack inside JOIN, slot 2 assigned
      clear_plan();
      ack_j = 2;
      slot_pat[3] = 2;
      run_round(1'b0);

      // member with only an out-of-range slot assignment, never acked
      clear_plan();
      slot_pat[1] = 5;
      run_round(1'b0);

      // CH saturation, last join on the window-expiry cycle
      clear_plan();
      join_pat[0] = 1'b1; join_pat[2] = 1'b1; join_pat[4] = 1'b1;
      join_pat[6] = 1'b1; join_pat[7] = 1'b1;
      run_round(1'b1);

      // low energy in the first frame, slot 1; start_round in TDMA ignored
      clear_plan();
      ack_j = 0;
      slot_pat[2] = 1;
      low_t = SLOT_LEN + 1;
      start_t = 3;
      run_round(1'b0);

      // reset mid-JOIN while the join request is outstanding
      clear_plan();
      abort_j = 3;
      run_round(1'b0);

      // last-wins slot assignment, slot 0 ignored
      clear_plan();
      slot_pat[1] = 1; slot_pat[4] = 3; slot_pat[6] = 0;
      run_round(1'b0);

      for (int r = 0; r < 24; r++) begin
         clear_plan();
         ann_ack = $urandom_range(0, 4);
         ack_j   = $urandom_range(0, JOIN_WIN + 1);
         for (int j = 0; j < JOIN_WIN; j++) begin
            join_pat[j] = ($urandom_range(0, 2) == 0);
            slot_pat[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
         end
         if ($urandom_range(0, 1) == 1) low_t = $urandom_range(0, FRAMES * FLEN - 1);
         if ($urandom_range(0, 2) == 0) start_t = $urandom_range(0, FLEN - 2);
         if ($urandom_range(0, 7) == 0) abort_j = $urandom_range(0, JOIN_WIN - 1);
         run_round(1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
